// File: rtl/tlp_detector.sv
// Byte-serial framed TLP detector placed after the 8b/10b decoder.
// Optional abort reporting (TLP_err, ERR_count) is enabled by defining TLP_DETECTOR_ERR_EN.
module tlp_detector #(
    parameter int         TLP_LEN = 20,
    parameter logic [7:0] STP_SYM = 8'hFB,
    parameter logic [7:0] END_SYM = 8'hFD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           data_in,
    input  logic                 datak,
`ifdef TLP_DETECTOR_ERR_EN
    output logic                 TLP_err,
    output logic [7:0]           ERR_count,
`endif
    output logic [7:0]           TLP_count,
    output logic [8*TLP_LEN-1:0] Data_out,
    output logic                 MRd,
    output logic                 MWr,
    output logic                 IORd,
    output logic                 IOWr,
    output logic                 CfgRd0,
    output logic                 CfgWr0,
    output logic                 CfgRd1,
    output logic                 CfgWr1,
    output logic                 Cpl,
    output logic                 CplD
);

    localparam int              IDX_W    = $clog2(TLP_LEN);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLP_LEN - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    // One-hot type flag vector, bit order MRd..CplD; unknown types decode to zero.
    function automatic logic [9:0] decode_type(input logic [7:0] fmt_type);
        logic [9:0] onehot;
        onehot = 10'b00_0000_0000;
        case (fmt_type)
            8'h00:   onehot = 10'b00_0000_0001;
            8'h01:   onehot = 10'b00_0000_0010;
            8'h02:   onehot = 10'b00_0000_0100;
            8'h42:   onehot = 10'b00_0000_1000;
            8'h04:   onehot = 10'b00_0001_0000;
            8'h44:   onehot = 10'b00_0010_0000;
            8'h05:   onehot = 10'b00_0100_0000;
            8'h45:   onehot = 10'b00_1000_0000;
            8'h0A:   onehot = 10'b01_0000_0000;
            8'h4A:   onehot = 10'b10_0000_0000;
            default: onehot = 10'b00_0000_0000;
        endcase
        return onehot;
    endfunction

    state_t                        state_r, state_s;
    logic [IDX_W-1:0]              idx_r, idx_s;
    logic [TLP_LEN-2:0][7:0]       buf_r;
    logic                          wr_en_s;
    logic [IDX_W-1:0]              wr_idx_s;
    logic                          frame_ok_s;
    logic                          abort_s;
    logic                          is_stp_s;
    logic                          is_end_s;
    logic [9:0]                    flags_r;
    logic [9:0]                    flags_s;

    assign is_stp_s = datak && (data_in == STP_SYM);
    assign is_end_s = datak && (data_in == END_SYM);

    // Framing FSM: decides where the current symbol goes and whether the frame completes or aborts.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        wr_en_s    = 1'b0;
        wr_idx_s   = idx_r;
        frame_ok_s = 1'b0;
        abort_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (is_stp_s) begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = IDX_ZERO;
                    idx_s    = IDX_ONE;
                    state_s  = ST_RECV;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                // A fresh STP always restarts the frame, even in the END slot.
                if (is_stp_s) begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = IDX_ZERO;
                    idx_s    = IDX_ONE;
                end else if (idx_r == LAST_IDX) begin
                    frame_ok_s = is_end_s;
                    abort_s    = !is_end_s;
                    idx_s      = IDX_ZERO;
                    state_s    = ST_IDLE;
                end else if (!datak) begin
                    wr_en_s = 1'b1;
                    idx_s   = idx_r + IDX_ONE;
                end else begin
                    abort_s = 1'b1;
                    idx_s   = IDX_ZERO;
                    state_s = ST_IDLE;
                end
            end
            default: begin
                idx_s   = IDX_ZERO;
                state_s = ST_IDLE;
            end
        endcase
    end

    assign flags_s = frame_ok_s ? decode_type(buf_r[3]) : 10'b00_0000_0000;

    // FSM state, byte index and capture buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            idx_r   <= IDX_ZERO;
            buf_r   <= {(8*(TLP_LEN-1)){1'b0}};
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            if (wr_en_s) begin
                buf_r[wr_idx_s] <= data_in;
            end
        end
    end

    // Frame outputs: snapshot, counter and type pulse all land on the END edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_r   <= 10'b00_0000_0000;
            TLP_count <= 8'h00;
            Data_out  <= {(8*TLP_LEN){1'b0}};
        end else begin
            flags_r <= flags_s;
            if (frame_ok_s) begin
                Data_out  <= {END_SYM, buf_r};
                TLP_count <= TLP_count + 8'h01;
            end
        end
    end

    assign MRd    = flags_r[0];
    assign MWr    = flags_r[1];
    assign IORd   = flags_r[2];
    assign IOWr   = flags_r[3];
    assign CfgRd0 = flags_r[4];
    assign CfgWr0 = flags_r[5];
    assign CfgRd1 = flags_r[6];
    assign CfgWr1 = flags_r[7];
    assign Cpl    = flags_r[8];
    assign CplD   = flags_r[9];

`ifdef TLP_DETECTOR_ERR_EN
    // Abort pulse and abort counter; resyncs are not aborts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            TLP_err   <= 1'b0;
            ERR_count <= 8'h00;
        end else begin
            TLP_err <= abort_s;
            if (abort_s) begin
                ERR_count <= ERR_count + 8'h01;
            end
        end
    end
`else
    logic unused_abort_s;
    assign unused_abort_s = abort_s;
`endif

endmodule

// File: tb/tb_tlp_detector.sv
// Directed self-checking bench for tlp_detector; inputs change 1 ns after the rising edge.
module tb_tlp_detector;

    logic         clk     = 1'b0;
    logic         reset   = 1'b1;
    logic [7:0]   data_in = 8'h00;
    logic         datak   = 1'b0;
    logic [7:0]   TLP_count;
    logic [159:0] Data_out;
    logic         MRd, MWr, IORd, IOWr, CfgRd0, CfgWr0, CfgRd1, CfgWr1, Cpl, CplD;
`ifdef TLP_DETECTOR_ERR_EN
    logic         TLP_err;
    logic [7:0]   ERR_count;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [9:0] flag_log [$];
    int         cyc_log  [$];
    logic [7:0] frm [0:20];
    logic       frk [0:20];
    logic [9:0] flags_v;
    logic [7:0] types [0:10] = '{8'h00, 8'h01, 8'h02, 8'h42, 8'h04, 8'h44,
                                 8'h05, 8'h45, 8'h0A, 8'h4A, 8'hAB};

    tlp_detector dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .datak     (datak),
`ifdef TLP_DETECTOR_ERR_EN
        .TLP_err   (TLP_err),
        .ERR_count (ERR_count),
`endif
        .TLP_count (TLP_count),
        .Data_out  (Data_out),
        .MRd       (MRd),
        .MWr       (MWr),
        .IORd      (IORd),
        .IOWr      (IOWr),
        .CfgRd0    (CfgRd0),
        .CfgWr0    (CfgWr0),
        .CfgRd1    (CfgRd1),
        .CfgWr1    (CfgWr1),
        .Cpl       (Cpl),
        .CplD      (CplD)
    );

    assign flags_v = {CplD, Cpl, CfgWr1, CfgRd1, CfgWr0, CfgRd0, IOWr, IORd, MWr, MRd};

    always #5 clk = ~clk;

    // Record every cycle on which any type flag is high.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (flags_v !== 10'b0) begin
            flag_log.push_back(flags_v);
            cyc_log.push_back(cyc);
        end
    end

    task automatic drive(input logic [7:0] d, input logic k);
        @(posedge clk);
        #1;
        data_in = d;
        datak   = k;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'h00, 1'b0);
    endtask

    task automatic build(input logic [7:0] t);
        frm[0] = 8'hFB; frk[0] = 1'b1;
        for (int i = 1; i < 19; i++) begin
            frm[i] = 8'(8'h10 + i);
            frk[i] = 1'b0;
        end
        frm[3]  = t;
        frm[19] = 8'hFD; frk[19] = 1'b1;
        frm[20] = 8'h00; frk[20] = 1'b0;
    endtask

    task automatic send(input int n);
        for (int i = 0; i < n; i++) drive(frm[i], frk[i]);
    endtask

    function automatic logic [159:0] exp_data();
        logic [159:0] v;
        for (int i = 0; i < 20; i++) v[8*i +: 8] = frm[i];
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b0;
        data_in = 8'h00;
        datak   = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        flag_log.delete();
        cyc_log.delete();
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        total++; if (TLP_count !== 8'h00) begin bad++; $display("FAIL reset_count: got %0h want 0", TLP_count); end
        total++; if (Data_out !== 160'h0) begin bad++; $display("FAIL reset_data: got %0h want 0", Data_out); end
        total++; if (flags_v !== 10'b0) begin bad++; $display("FAIL reset_flags: got %0h want 0", flags_v); end
        @(negedge clk);
        reset = 1'b1;
        flag_log.delete();
        cyc_log.delete();
    endtask

    task automatic test_single();
        do_reset();
        frm[0] = 8'hFB; frk[0] = 1'b1;
        frm[1] = 8'h00; frm[2] = 8'h00; frm[3] = 8'h0A;
        for (int i = 4; i < 15; i++) frm[i] = 8'(i - 3);
        frm[15] = 8'hFF; frm[16] = 8'hA5; frm[17] = 8'hA5; frm[18] = 8'hFF;
        for (int i = 1; i < 19; i++) frk[i] = 1'b0;
        frm[19] = 8'hFD; frk[19] = 1'b1;
        send(20);
        idle(1);
        total++; if (TLP_count !== 8'd1) begin bad++; $display("FAIL single_count: got %0d want 1", TLP_count); end
        total++; if (Data_out !== 160'hFD_ffa5a5ff_0b0a090807060504030201_0a_0000_FB) begin
            bad++; $display("FAIL single_data: got %0h", Data_out); end
        idle(3);
        total++; if (flag_log.size() !== 1) begin bad++; $display("FAIL single_npulse: got %0d want 1", flag_log.size()); end
        else begin
            total++; if (flag_log[0] !== 10'h100) begin bad++; $display("FAIL single_cpl: got %0h want 100", flag_log[0]); end
        end
    endtask

    task automatic test_all_types();
        do_reset();
        for (int f = 0; f < 11; f++) begin
            build(types[f]);
            send(20);
            idle(2);
        end
        idle(2);
        total++; if (TLP_count !== 8'd11) begin bad++; $display("FAIL types_count: got %0d want 11", TLP_count); end
        total++; if (Data_out !== exp_data()) begin bad++; $display("FAIL types_data: got %0h want %0h", Data_out, exp_data()); end
        total++; if (flag_log.size() !== 10) begin bad++; $display("FAIL types_npulse: got %0d want 10", flag_log.size()); end
        else begin
            for (int i = 0; i < 10; i++) begin
                total++;
                if (flag_log[i] !== (10'b1 << i)) begin
                    bad++; $display("FAIL types_flag%0d: got %0h want %0h", i, flag_log[i], 10'b1 << i);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        build(8'h00); send(20);
        build(8'h01); send(20);
        idle(3);
        total++; if (TLP_count !== 8'd2) begin bad++; $display("FAIL b2b_count: got %0d want 2", TLP_count); end
        total++; if (flag_log.size() !== 2) begin bad++; $display("FAIL b2b_npulse: got %0d want 2", flag_log.size()); end
        else begin
            total++; if (flag_log[0] !== 10'h001 || flag_log[1] !== 10'h002) begin
                bad++; $display("FAIL b2b_order: got %0h,%0h want 1,2", flag_log[0], flag_log[1]); end
            total++; if (cyc_log[1] - cyc_log[0] !== 20) begin
                bad++; $display("FAIL b2b_spacing: got %0d want 20", cyc_log[1] - cyc_log[0]); end
        end
        do_reset();
        build(8'h00); send(20); idle(1);
        build(8'h01); send(20);
        idle(3);
        total++; if (TLP_count !== 8'd2) begin bad++; $display("FAIL gap1_count: got %0d want 2", TLP_count); end
        total++; if (Data_out !== exp_data()) begin bad++; $display("FAIL gap1_data: got %0h want %0h", Data_out, exp_data()); end
    endtask

    task automatic test_malformed();
        do_reset();
        build(8'h00); frm[0] = 8'hFD; send(20); idle(2);
        build(8'h00); frk[0] = 1'b0; send(20); idle(2);
        build(8'h00); frm[19] = 8'hFB; send(20); idle(2);
        build(8'h00); frk[1] = 1'b1; send(20);
        idle(3);
        total++; if (TLP_count !== 8'd0) begin bad++; $display("FAIL bad_count: got %0d want 0", TLP_count); end
        total++; if (Data_out !== 160'h0) begin bad++; $display("FAIL bad_data: got %0h want 0", Data_out); end
        total++; if (flag_log.size() !== 0) begin bad++; $display("FAIL bad_npulse: got %0d want 0", flag_log.size()); end
`ifdef TLP_DETECTOR_ERR_EN
        total++; if (ERR_count !== 8'd1) begin bad++; $display("FAIL bad_errcount: got %0d want 1", ERR_count); end
`endif
    endtask

    task automatic test_length();
        do_reset();
        build(8'h00); frm[18] = 8'hFD; frk[18] = 1'b1; send(19); idle(2);
        build(8'h00); frm[19] = 8'h23; frk[19] = 1'b0; frm[20] = 8'hFD; frk[20] = 1'b1; send(21);
        idle(3);
        total++; if (TLP_count !== 8'd0) begin bad++; $display("FAIL len_count: got %0d want 0", TLP_count); end
        total++; if (flag_log.size() !== 0) begin bad++; $display("FAIL len_npulse: got %0d want 0", flag_log.size()); end
`ifdef TLP_DETECTOR_ERR_EN
        total++; if (ERR_count !== 8'd2) begin bad++; $display("FAIL len_errcount: got %0d want 2", ERR_count); end
`endif
    endtask

    task automatic test_skew_and_reset();
        do_reset();
        build(8'h04); send(20);
        build(8'h4A); send(20);
        build(8'h0A); send(20);
        idle(3);
        total++; if (TLP_count !== 8'd3) begin bad++; $display("FAIL skew_count: got %0d want 3", TLP_count); end
        total++; if (Data_out !== exp_data()) begin bad++; $display("FAIL skew_data: got %0h want %0h", Data_out, exp_data()); end
        total++; if (flag_log.size() !== 3) begin bad++; $display("FAIL skew_npulse: got %0d want 3", flag_log.size()); end
        else begin
            total++; if (flag_log[0] !== 10'h010 || flag_log[1] !== 10'h200 || flag_log[2] !== 10'h100) begin
                bad++; $display("FAIL skew_order: got %0h,%0h,%0h want 10,200,100", flag_log[0], flag_log[1], flag_log[2]); end
        end
        build(8'h01); send(10);
        #3 reset = 1'b0;
        #1;
        total++; if (TLP_count !== 8'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", TLP_count); end
        total++; if (Data_out !== 160'h0) begin bad++; $display("FAIL midrst_data: got %0h want 0", Data_out); end
        @(negedge clk);
        reset = 1'b1;
        flag_log.delete();
        cyc_log.delete();
        build(8'h01); send(20);
        idle(3);
        total++; if (TLP_count !== 8'd1) begin bad++; $display("FAIL postrst_count: got %0d want 1", TLP_count); end
        total++; if (flag_log.size() !== 1) begin bad++; $display("FAIL postrst_npulse: got %0d want 1", flag_log.size()); end
        else begin
            total++; if (flag_log[0] !== 10'h002) begin bad++; $display("FAIL postrst_mwr: got %0h want 2", flag_log[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_types();
        test_back_to_back();
        test_malformed();
        test_length();
        test_skew_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
